pad_port_arbiter: RTL and testbench

//   Assigns up to four Pocket controllers to the two MSX joystick ports (A, B).
//   A controller claims a free port by holding Start; it keeps that port until it

---
 rtl/pad_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_pad_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_port_arbiter.sv
// Pocket controller to MSX joystick port arbiter.
// Up to four pads compete for two joystick ports (A and B). A pad claims a free
// port by holding Start. It keeps that port until it disconnects or stays idle
// for TIMEOUT_TICKS millisecond strobes. The PSG joystick mux downstream routes
// pad bits using port_*_sel, and it must gate them with port_*_valid.
module pad_port_arbiter #(
    parameter int NUM_PADS      = 4,
    parameter int TIMEOUT_TICKS = 5000
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                tick_ms,
    input  logic [NUM_PADS-1:0] pad_connected,
    input  logic [NUM_PADS-1:0] pad_claim,
    input  logic [NUM_PADS-1:0] pad_active,
    output logic                port_a_valid,
    output logic [1:0]          port_a_sel,
    output logic                port_b_valid,
    output logic [1:0]          port_b_sel,
    output logic                port_event
);

    // Index 0 is port A and index 1 is port B throughout this file.
    localparam int NUM_PORTS = 2;
    localparam int MAX_PADS  = 4;

    // The idle counter only needs to reach TIMEOUT_TICKS and then saturate.
    // When the timeout is disabled, a 1-bit counter that is held at zero is kept
    // so that the declarations stay legal.
    localparam bit             TIMEOUT_EN  = (TIMEOUT_TICKS > 0);
    localparam int             CNT_W       = TIMEOUT_EN ? $clog2(TIMEOUT_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic {
        PORT_FREE  = 1'b0,
        PORT_OWNED = 1'b1
    } port_state_e;

    port_state_e      state_q [NUM_PORTS];
    port_state_e      state_d [NUM_PORTS];
    logic [1:0]       sel_q   [NUM_PORTS];
    logic [1:0]       sel_d   [NUM_PORTS];
    logic [CNT_W-1:0] idle_q  [NUM_PORTS];
    logic [CNT_W-1:0] idle_d  [NUM_PORTS];
    logic             event_q;
    logic             event_d;

    logic [MAX_PADS-1:0]  conn_m;
    logic [MAX_PADS-1:0]  claim_m;
    logic [MAX_PADS-1:0]  active_m;
    logic [MAX_PADS-1:0]  owner_mask;
    logic [MAX_PADS-1:0]  eligible;
    logic                 grant_any;
    logic [1:0]           grant_idx;
    logic [NUM_PORTS-1:0] grant_port;
    logic [NUM_PORTS-1:0] release_port;

    // Pad slots above NUM_PADS are tied off. Everything downstream can then
    // index a fixed 4-wide vector with the 2-bit sel value.
    for (genvar i = 0; i < MAX_PADS; i++) begin : g_pad_mask
        if (i < NUM_PADS) begin : g_live
            assign conn_m[i]   = pad_connected[i];
            assign claim_m[i]  = pad_claim[i];
            assign active_m[i] = pad_active[i];
        end else begin : g_absent
            assign conn_m[i]   = 1'b0;
            assign claim_m[i]  = 1'b0;
            assign active_m[i] = 1'b0;
        end
    end

    // Mark the pads that currently own a port. A releasing owner is still
    // marked this cycle, so it cannot re-claim on the cycle it lets go.
    always_comb begin
        owner_mask = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (state_q[p] == PORT_OWNED) begin
                owner_mask[sel_q[p]] = 1'b1;
            end
        end
    end

    // Pick the lowest-index eligible claimer. Only one grant is made per cycle.
    always_comb begin
        eligible  = claim_m & conn_m & ~owner_mask;
        grant_any = 1'b0;
        grant_idx = 2'd0;
        for (int i = MAX_PADS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                grant_any = 1'b1;
                grant_idx = 2'(i);
            end
        end
    end

    // Choose the target port. Only a port that is FREE right now can be granted.
    // A port that is releasing this cycle therefore stays FREE for one cycle
    // before anyone gets it.
    always_comb begin
        grant_port    = '0;
        grant_port[0] = grant_any && (state_q[0] == PORT_FREE);
        grant_port[1] = grant_any && (state_q[0] != PORT_FREE) && (state_q[1] == PORT_FREE);
    end

    // Release an owned port when its owner disconnects or its idle count expires.
    always_comb begin
        release_port = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (state_q[p] == PORT_OWNED) begin
                if (!conn_m[sel_q[p]]) begin
                    release_port[p] = 1'b1;
                end else if (TIMEOUT_EN && (idle_q[p] == TIMEOUT_VAL)) begin
                    release_port[p] = 1'b1;
                end
            end
        end
    end

    // Compute the next port state, owner and idle count. sel is only rewritten
    // on a grant, so it keeps the last owner after a release.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            state_d[p] = state_q[p];
            sel_d[p]   = sel_q[p];
            idle_d[p]  = idle_q[p];
        end
        event_d = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (release_port[p]) begin
                state_d[p] = PORT_FREE;
                idle_d[p]  = '0;
            end else if (grant_port[p]) begin
                state_d[p] = PORT_OWNED;
                sel_d[p]   = grant_idx;
                idle_d[p]  = '0;
            end else if (state_q[p] == PORT_OWNED) begin
                if (active_m[sel_q[p]]) begin
                    idle_d[p] = '0;
                end else if (TIMEOUT_EN && tick_ms && (idle_q[p] != TIMEOUT_VAL)) begin
                    idle_d[p] = idle_q[p] + CNT_ONE;
                end
            end else begin
                idle_d[p] = '0;
            end
        end
        event_d = (|grant_port) | (|release_port);
    end

    // Register the port state. An asynchronous reset frees both ports at once.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= PORT_FREE;
                sel_q[p]   <= 2'd0;
                idle_q[p]  <= '0;
            end
            event_q <= 1'b0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                state_q[p] <= state_d[p];
                sel_q[p]   <= sel_d[p];
                idle_q[p]  <= idle_d[p];
            end
            event_q <= event_d;
        end
    end

    assign port_a_valid = (state_q[0] == PORT_OWNED);
    assign port_a_sel   = sel_q[0];
    assign port_b_valid = (state_q[1] == PORT_OWNED);
    assign port_b_sel   = sel_q[1];
    assign port_event   = event_q;

endmodule

// File: tb/tb_pad_port_arbiter.sv
// Directed testbench for pad_port_arbiter. The timeout is set to 3 ticks so the
// idle-release path can be reached in a few cycles. Each check compares the
// packed vector {a_valid, a_sel, b_valid, b_sel, event} against a hand-derived
// expected value.
module tb_pad_port_arbiter;

    logic       clk_sys;
    logic       reset;
    logic       tick_ms;
    logic [3:0] pad_connected;
    logic [3:0] pad_claim;
    logic [3:0] pad_active;
    logic       port_a_valid;
    logic [1:0] port_a_sel;
    logic       port_b_valid;
    logic [1:0] port_b_sel;
    logic       port_event;

    int n_compared;
    int n_mismatched;

    logic [6:0] observed;
    logic [6:0] expected;

    pad_port_arbiter #(
        .NUM_PADS      (4),
        .TIMEOUT_TICKS (3)
    ) dut (
        .clk_sys       (clk_sys),
        .reset         (reset),
        .tick_ms       (tick_ms),
        .pad_connected (pad_connected),
        .pad_claim     (pad_claim),
        .pad_active    (pad_active),
        .port_a_valid  (port_a_valid),
        .port_a_sel    (port_a_sel),
        .port_b_valid  (port_b_valid),
        .port_b_sel    (port_b_sel),
        .port_event    (port_event)
    );

    // 100 MHz free-running clock.
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Advance one rising edge, then settle 1 ns past it before anything is sampled.
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Hold tick_ms high across exactly one rising edge.
    task automatic tick_pulse();
        tick_ms = 1'b1;
        step();
        tick_ms = 1'b0;
    endtask

    // Pack the outputs as {a_valid, a_sel[1:0], b_valid, b_sel[1:0], event}.
    function automatic logic [6:0] pack_outputs();
        return {port_a_valid, port_a_sel, port_b_valid, port_b_sel, port_event};
    endfunction

    // Put the arbiter back into reset with all pads connected and idle.
    task automatic do_reset();
        reset         = 1'b1;
        tick_ms       = 1'b0;
        pad_claim     = 4'b0000;
        pad_active    = 4'b0000;
        pad_connected = 4'b1111;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        tick_ms       = 1'b0;
        pad_claim     = 4'b0000;
        pad_active    = 4'b0000;
        pad_connected = 4'b1111;
        reset         = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        observed = pack_outputs();
        expected = 7'b0_00_0_00_0;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL reset_async got %b want %b", observed, expected);
        end
        step();
        reset = 1'b0;
        step();
        observed = pack_outputs();
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL reset_idle got %b want %b", observed, expected);
        end
    endtask

    task automatic test_single_claim();
        do_reset();
        pad_claim = 4'b0001;
        step();
        observed = pack_outputs();
        expected = 7'b1_00_0_00_1;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL single_grant got %b want %b", observed, expected);
        end
        step();
        observed = pack_outputs();
        expected = 7'b1_00_0_00_0;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL single_hold got %b want %b", observed, expected);
        end
        pad_claim = 4'b0000;
    endtask

    task automatic test_back_to_back();
        do_reset();
        pad_claim = 4'b0110;
        step();
        observed = pack_outputs();
        expected = 7'b1_01_0_00_1;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_first got %b want %b", observed, expected);
        end
        step();
        observed = pack_outputs();
        expected = 7'b1_01_1_10_1;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_second got %b want %b", observed, expected);
        end
        step();
        observed = pack_outputs();
        expected = 7'b1_01_1_10_0;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_owners_hold got %b want %b", observed, expected);
        end
        pad_claim = 4'b1000;
        step();
        step();
        observed = pack_outputs();
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_third_ignored got %b want %b", observed, expected);
        end
        pad_claim = 4'b0000;
    endtask

    task automatic test_disconnect();
        do_reset();
        pad_claim = 4'b0001;
        step();
        pad_claim = 4'b0010;
        step();
        pad_claim = 4'b0000;
        observed = pack_outputs();
        expected = 7'b1_00_1_01_1;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL disc_setup got %b want %b", observed, expected);
        end
        pad_connected = 4'b1110;
        pad_claim     = 4'b1000;
        step();
        observed = pack_outputs();
        expected = 7'b0_00_1_01_1;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL disc_release got %b want %b", observed, expected);
        end
        step();
        observed = pack_outputs();
        expected = 7'b1_11_1_01_1;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL disc_regrant got %b want %b", observed, expected);
        end
        pad_claim = 4'b0000;
        step();
        observed = pack_outputs();
        expected = 7'b1_11_1_01_0;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL disc_settle got %b want %b", observed, expected);
        end
        pad_connected = 4'b1111;
    endtask

    task automatic test_timeout();
        do_reset();
        pad_claim = 4'b0001;
        step();
        pad_claim = 4'b0000;
        tick_pulse();
        step();
        tick_pulse();
        observed = pack_outputs();
        expected = 7'b1_00_0_00_0;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL tmo_two_ticks got %b want %b", observed, expected);
        end
        pad_active = 4'b0001;
        step();
        pad_active = 4'b0000;
        tick_pulse();
        step();
        tick_pulse();
        step();
        observed = pack_outputs();
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL tmo_active_cleared got %b want %b", observed, expected);
        end
        tick_pulse();
        observed = pack_outputs();
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL tmo_third_tick got %b want %b", observed, expected);
        end
        step();
        observed = pack_outputs();
        expected = 7'b0_00_0_00_1;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL tmo_release got %b want %b", observed, expected);
        end
        step();
        observed = pack_outputs();
        expected = 7'b0_00_0_00_0;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL tmo_free got %b want %b", observed, expected);
        end
    endtask

    task automatic test_release_claim_same_cycle();
        do_reset();
        pad_claim = 4'b0001;
        step();
        pad_claim = 4'b0010;
        step();
        pad_claim  = 4'b0000;
        pad_active = 4'b0010;
        tick_pulse();
        tick_pulse();
        tick_pulse();
        pad_claim = 4'b1000;
        step();
        observed = pack_outputs();
        expected = 7'b0_00_1_01_1;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL rc_release_wins got %b want %b", observed, expected);
        end
        step();
        observed = pack_outputs();
        expected = 7'b1_11_1_01_1;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL rc_granted_after got %b want %b", observed, expected);
        end
        pad_claim  = 4'b0000;
        pad_active = 4'b0000;
    endtask

    task automatic test_async_reset_owned();
        do_reset();
        pad_claim = 4'b0001;
        step();
        pad_claim = 4'b0100;
        step();
        pad_claim = 4'b0000;
        observed = pack_outputs();
        expected = 7'b1_00_1_10_1;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL areset_setup got %b want %b", observed, expected);
        end
        #3;
        reset = 1'b1;
        #1;
        observed = pack_outputs();
        expected = 7'b0_00_0_00_0;
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL areset_immediate got %b want %b", observed, expected);
        end
        step();
        reset = 1'b0;
    endtask

    // Run every scenario in order, then print the summary line.
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_single_claim();
        test_back_to_back();
        test_disconnect();
        test_timeout();
        test_release_claim_same_cycle();
        test_async_reset_owned();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
